wt_dcache_shct_predictor: RTL and testbench
===========================================

Name: wt_dcache_shct_predictor

Overview:
- Parametrised signature-history counter table (SHCT) for signature-based insertion prediction in the write-through L1 dcache.
- Lookup takes a miss signature; after one cycle it returns the counter and a "distant reference" flag that the replacement logic uses to pick the insertion age.
- Training: hits increment the counter for a signature; evictions of lines never reused decrement it.
- Adds over the previous predictor:
  - configurable table depth, counter width and way count;
  - multi-cycle init/flush sweep with a ready signal;
  - registered lookup;
  - deterministic merging of same-cycle updates that target the same entry.

Parameters:
- SigWidth, 14, signature width; table depth is 2**SigWidth entries.
- CtrWidth, 2, saturating counter width.
- NumWays, 4, eviction training ports, one per way.
- CtrInit, 2**CtrWidth-1, value written by the init/flush sweep.
- DistantThr, 0, counter value at or below which pred_distant_o=1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  one-cycle pulse; restarts the init sweep
- ready_o  out  1  table initialised; lookups and updates accepted
- lookup_valid_i  in  1  prediction request
- lookup_sig_i  in  SigWidth  signature of the missing access
- pred_valid_o  out  1  prediction valid, one cycle after an accepted lookup
- pred_ctr_o  out  CtrWidth  counter value read
- pred_distant_o  out  1  pred_ctr_o <= DistantThr
- hit_valid_i  in  1  train: cache hit
- hit_sig_i  in  SigWidth  signature of the hit line
- evict_valid_i  in  NumWays  per-way eviction training strobe
- evict_sig_i  in  NumWays x SigWidth  signature of each evicted line
- evict_reused_i  in  NumWays  evicted line was hit at least once

Behaviour:
- Storage is 2**SigWidth x CtrWidth. The storage has no reset; it is initialised only by the sweep.
- FSM states: INIT and RUN.
  - Async reset: state=INIT, sweep index=0, ready_o=0, pred_valid_o=0, pred_ctr_o=0, pred_distant_o=0.
  - INIT: writes CtrInit to entry[idx] each cycle, then idx++.
  - At idx=2**SigWidth-1, the write occurs and the next state is RUN. ready_o=1 from the following cycle. The sweep takes exactly 2**SigWidth cycles.
  - RUN: on flush_i, go to INIT with idx=0. That cycle's updates are dropped.
  - flush_i while in INIT: idx restarts at 0.
  - Reset mid-sweep: sweep restarts from 0.
- While ready_o=0:
  - lookups are ignored; pred_valid_o=0 next cycle;
  - all training inputs are ignored.
- Lookup (lookup_valid_i & ready_o):
  - pred_valid_o=1 on the next cycle, for one cycle only.
  - pred_ctr_o holds the entry value before any same-cycle training is committed (read-before-write).
  - pred_ctr_o and pred_distant_o hold their value until the next accepted lookup.
- Training (ready_o=1):
  - Contributions: hit_valid_i gives +1 to entry[hit_sig_i]. Each way w with evict_valid_i[w]=1 and evict_reused_i[w]=0 gives -1 to entry[evict_sig_i[w]]. A reused eviction contributes 0.
  - Merge: all contributions targeting the same index in one cycle are summed into a signed net delta, range -NumWays..+1.
  - Each touched entry gets exactly one write at the end of the cycle: new = clamp(old + net, 0, 2**CtrWidth-1).
  - Untouched entries are unchanged.
  - Duplicate signatures across ports must yield a single consistent result, never last-writer-wins.
- Width and arithmetic:
  - Compute net delta and sum in CtrWidth+$clog2(NumWays+2)+1 signed bits before clamping.
  - No wrap-around at 0 or at the maximum value.

Test Plan:
- Reset, then count cycles until ready_o=1 → exactly 2**SigWidth cycles (16384 with defaults). A subsequent lookup of sig 0x0000 and of sig 0x3FFF both return ctr=3, distant=0.
- Three hits on sig 0x0123 followed by a lookup → ctr=3, since the counter saturates and does not wrap to 0.
- Four non-reused evictions of sig 0x0123 in consecutive cycles, then a lookup → ctr=0 and distant=1. A fifth eviction keeps ctr=0.
- Same-cycle merge on sig 0x0055 starting at ctr=2: hit, plus ways 0, 1 and 2 evicting it non-reused, plus way 3 evicting it reused → net -2, lookup gives ctr=0. Repeat from 3 with hit plus one non-reused eviction → ctr=3.
- Lookup and hit on sig 0x0AAA in the same cycle with ctr=1 → pred_ctr_o=1; a lookup on the next cycle gives 2.
- flush_i mid-RUN after training sig 0x0123 to 0, and separately asserted halfway through the sweep → ready_o drops next cycle, returns after a full 2**SigWidth-cycle sweep. Lookups during the sweep give pred_valid_o=0. After the sweep, sig 0x0123 reads ctr=3.

Source files
------------

// File: rtl/wt_dcache_shct_predictor.sv
// wt_dcache_shct_predictor: signature-history counter table with init/flush sweep,
// registered lookup and merged same-cycle training updates.
module wt_dcache_shct_predictor #(
    parameter int unsigned SigWidth   = 14,
    parameter int unsigned CtrWidth   = 2,
    parameter int unsigned NumWays    = 4,
    parameter int unsigned CtrInit    = 2**CtrWidth-1,
    parameter int          DistantThr = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    output logic                               ready_o,
    input  logic                               lookup_valid_i,
    input  logic [SigWidth-1:0]                lookup_sig_i,
    output logic                               pred_valid_o,
    output logic [CtrWidth-1:0]                pred_ctr_o,
    output logic                               pred_distant_o,
    input  logic                               hit_valid_i,
    input  logic [SigWidth-1:0]                hit_sig_i,
    input  logic [NumWays-1:0]                 evict_valid_i,
    input  logic [NumWays-1:0][SigWidth-1:0]   evict_sig_i,
    input  logic [NumWays-1:0]                 evict_reused_i
);
    localparam int Depth    = 2**SigWidth;
    localparam int NumPorts = NumWays + 1;
    localparam int DW       = CtrWidth + $clog2(NumWays + 2) + 1;
    localparam logic [CtrWidth-1:0] InitVal = CtrInit[CtrWidth-1:0];
    localparam logic signed [DW-1:0] CtrTop = {{(DW-CtrWidth){1'b0}}, {CtrWidth{1'b1}}};

    typedef enum logic {INIT, RUN} state_e;

    state_e               state_q, state_d;
    logic [SigWidth-1:0]  idx_q, idx_d;
    logic [CtrWidth-1:0]  mem [Depth];
    logic                 train;
    logic [SigWidth-1:0]  sig [NumPorts];
    logic signed [DW-1:0] con [NumPorts];
    logic signed [DW-1:0] net [NumPorts];
    logic signed [DW-1:0] sum [NumPorts];
    logic [CtrWidth-1:0]  upd [NumPorts];

    assign ready_o = state_q == RUN;
    assign train   = ready_o && !flush_i;

    always_comb begin
        state_d = flush_i ? INIT : (state_q == INIT && &idx_q) ? RUN : state_q;
        idx_d   = (state_q == RUN || flush_i) ? '0 : idx_q + SigWidth'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= INIT;
            idx_q          <= '0;
            pred_valid_o   <= 1'b0;
            pred_ctr_o     <= '0;
            pred_distant_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pred_valid_o <= lookup_valid_i && ready_o;
            if (lookup_valid_i && ready_o) begin
                pred_ctr_o     <= mem[lookup_sig_i];
                pred_distant_o <= (int'(mem[lookup_sig_i]) <= DistantThr);
            end
        end
    end

    // Port 0 is the hit (+1); ports 1..NumWays are way evictions (-1 unless reused).
    always_comb begin
        sig[0] = hit_sig_i;
        con[0] = {{(DW-1){1'b0}}, train && hit_valid_i};
        for (int w = 0; w < NumWays; w++) begin
            sig[w+1] = evict_sig_i[w];
            con[w+1] = {DW{train && evict_valid_i[w] && !evict_reused_i[w]}};
        end
    end

    // Every port sums all contributions aimed at its index, so ports sharing an
    // index compute identical write data and the write order is irrelevant.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            net[p] = '0;
            for (int q = 0; q < NumPorts; q++)
                net[p] = net[p] + ((sig[q] == sig[p]) ? con[q] : '0);
            sum[p] = $signed({{(DW-CtrWidth){1'b0}}, mem[sig[p]]}) + net[p];
            upd[p] = sum[p][DW-1] ? '0 : (sum[p] > CtrTop) ? '1 : sum[p][CtrWidth-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == INIT)
            mem[idx_q] <= InitVal;
        else
            for (int p = 0; p < NumPorts; p++)
                if (con[p] != '0)
                    mem[sig[p]] <= upd[p];
    end
endmodule

// File: tb/tb_wt_dcache_shct_predictor.sv
// tb_wt_dcache_shct_predictor: scenario tasks plus randomized training/lookup traffic
// checked against an array-based counter table model.
module tb_wt_dcache_shct_predictor;
    localparam int SW = 14;
    localparam int CW = 2;
    localparam int NW = 4;
    localparam int DEPTH = 1 << SW;
    localparam int CMAX = (1 << CW) - 1;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   flush_i;
    logic                   ready_o;
    logic                   lookup_valid_i;
    logic [SW-1:0]          lookup_sig_i;
    logic                   pred_valid_o;
    logic [CW-1:0]          pred_ctr_o;
    logic                   pred_distant_o;
    logic                   hit_valid_i;
    logic [SW-1:0]          hit_sig_i;
    logic [NW-1:0]          evict_valid_i;
    logic [NW-1:0][SW-1:0]  evict_sig_i;
    logic [NW-1:0]          evict_reused_i;

    int model [DEPTH];
    int sweep_left;
    bit e_pv;
    int e_ctr;
    int checks;
    int failures;

    wt_dcache_shct_predictor dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .ready_o(ready_o),
        .lookup_valid_i(lookup_valid_i), .lookup_sig_i(lookup_sig_i),
        .pred_valid_o(pred_valid_o), .pred_ctr_o(pred_ctr_o), .pred_distant_o(pred_distant_o),
        .hit_valid_i(hit_valid_i), .hit_sig_i(hit_sig_i),
        .evict_valid_i(evict_valid_i), .evict_sig_i(evict_sig_i), .evict_reused_i(evict_reused_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic clear();
        flush_i = 0; lookup_valid_i = 0; lookup_sig_i = '0; hit_valid_i = 0; hit_sig_i = '0;
        evict_valid_i = '0; evict_sig_i = '0; evict_reused_i = '0;
    endtask

    // Advance the model by one cycle using the currently driven inputs, then clock the DUT.
    task automatic tick();
        int d [int];
        int v;
        bit rdy;
        rdy = (sweep_left == 0);
        if (rdy && lookup_valid_i) begin
            e_pv = 1; e_ctr = model[lookup_sig_i];
        end else e_pv = 0;
        if (rdy && !flush_i) begin
            if (hit_valid_i) d[hit_sig_i] = (d.exists(hit_sig_i) ? d[hit_sig_i] : 0) + 1;
            for (int w = 0; w < NW; w++)
                if (evict_valid_i[w] && !evict_reused_i[w])
                    d[evict_sig_i[w]] = (d.exists(evict_sig_i[w]) ? d[evict_sig_i[w]] : 0) - 1;
            foreach (d[k]) begin
                v = model[k] + d[k];
                model[k] = v < 0 ? 0 : (v > CMAX ? CMAX : v);
            end
        end
        if (flush_i) sweep_left = DEPTH;
        else if (!rdy) begin
            sweep_left--;
            if (sweep_left == 0) foreach (model[i]) model[i] = CMAX;
        end
        @(posedge clk_i); #1;
    endtask

    // Run the sweep to completion with random lookups that must all be ignored.
    task automatic sweep_wait(input string tag, input int exp_cycles);
        int n = 0;
        while (!ready_o && n < 20000) begin
            lookup_valid_i = 1; lookup_sig_i = SW'($urandom);
            tick(); n++;
            checks++;
            if (pred_valid_o !== 1'b0) begin
                failures++; $display("FAIL %s_pv_during_sweep got=%b exp=0 cycle=%0d", tag, pred_valid_o, n);
            end
        end
        clear();
        checks++;
        if (n !== exp_cycles) begin
            failures++; $display("FAIL %s_sweep_len got=%0d exp=%0d", tag, n, exp_cycles);
        end
    endtask

    task automatic test_reset();
        clear(); rst_ni = 0;
        repeat (3) @(posedge clk_i);
        #1;
        checks += 4;
        if (ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready_o); end
        if (pred_valid_o !== 1'b0) begin failures++; $display("FAIL rst_pv got=%b exp=0", pred_valid_o); end
        if (pred_ctr_o !== '0) begin failures++; $display("FAIL rst_ctr got=%0d exp=0", pred_ctr_o); end
        if (pred_distant_o !== 1'b0) begin failures++; $display("FAIL rst_distant got=%b exp=0", pred_distant_o); end
        rst_ni = 1; sweep_left = DEPTH; e_pv = 0; e_ctr = 0;
        sweep_wait("init", DEPTH);
    endtask

    task automatic test_init_lookup();
        logic [SW-1:0] s [2];
        s[0] = '0; s[1] = '1;
        for (int i = 0; i < 2; i++) begin
            lookup_valid_i = 1; lookup_sig_i = s[i];
            tick();
            checks += 3;
            if (pred_valid_o !== 1'b1) begin failures++; $display("FAIL init_pv sig=%h got=%b exp=1", s[i], pred_valid_o); end
            if (pred_ctr_o !== 2'd3) begin failures++; $display("FAIL init_ctr sig=%h got=%0d exp=3", s[i], pred_ctr_o); end
            if (pred_distant_o !== 1'b0) begin failures++; $display("FAIL init_distant sig=%h got=%b exp=0", s[i], pred_distant_o); end
        end
        clear(); tick();
        checks += 2;
        if (pred_valid_o !== 1'b0) begin failures++; $display("FAIL pv_one_cycle got=%b exp=0", pred_valid_o); end
        if (pred_ctr_o !== 2'd3) begin failures++; $display("FAIL ctr_hold got=%0d exp=3", pred_ctr_o); end
    endtask

    task automatic test_hit_saturate();
        repeat (3) begin hit_valid_i = 1; hit_sig_i = 14'h0123; tick(); end
        clear(); lookup_valid_i = 1; lookup_sig_i = 14'h0123; tick(); clear();
        checks++;
        if (pred_ctr_o !== 2'd3) begin failures++; $display("FAIL hit_saturate got=%0d exp=3", pred_ctr_o); end
    endtask

    task automatic test_evict_floor();
        for (int i = 0; i < 5; i++) begin
            evict_valid_i[0] = 1; evict_sig_i[0] = 14'h0123; tick();
            if (i >= 3) begin
                clear(); lookup_valid_i = 1; lookup_sig_i = 14'h0123; tick(); clear();
                checks += 2;
                if (pred_ctr_o !== 2'd0) begin failures++; $display("FAIL evict_floor%0d got=%0d exp=0", i, pred_ctr_o); end
                if (pred_distant_o !== 1'b1) begin failures++; $display("FAIL evict_distant%0d got=%b exp=1", i, pred_distant_o); end
            end
        end
    endtask

    task automatic test_merge();
        evict_valid_i[2] = 1; evict_sig_i[2] = 14'h0055; tick(); clear();
        hit_valid_i = 1; hit_sig_i = 14'h0055;
        evict_valid_i = 4'hF; evict_reused_i = 4'b1000;
        for (int w = 0; w < NW; w++) evict_sig_i[w] = 14'h0055;
        tick(); clear();
        lookup_valid_i = 1; lookup_sig_i = 14'h0055; tick(); clear();
        checks++;
        if (pred_ctr_o !== 2'd0) begin failures++; $display("FAIL merge_neg2 got=%0d exp=0", pred_ctr_o); end
        repeat (3) begin hit_valid_i = 1; hit_sig_i = 14'h0055; tick(); end
        evict_valid_i[1] = 1; evict_sig_i[1] = 14'h0055; tick(); clear();
        lookup_valid_i = 1; lookup_sig_i = 14'h0055; tick(); clear();
        checks++;
        if (pred_ctr_o !== 2'd3) begin failures++; $display("FAIL merge_zero got=%0d exp=3", pred_ctr_o); end
    endtask

    task automatic test_read_before_write();
        evict_valid_i = 4'b0101; evict_sig_i[0] = 14'h0AAA; evict_sig_i[2] = 14'h0AAA; tick(); clear();
        lookup_valid_i = 1; lookup_sig_i = 14'h0AAA; hit_valid_i = 1; hit_sig_i = 14'h0AAA; tick(); clear();
        checks++;
        if (pred_ctr_o !== 2'd1) begin failures++; $display("FAIL rbw_same_cycle got=%0d exp=1", pred_ctr_o); end
        lookup_valid_i = 1; lookup_sig_i = 14'h0AAA; tick(); clear();
        checks++;
        if (pred_ctr_o !== 2'd2) begin failures++; $display("FAIL rbw_next got=%0d exp=2", pred_ctr_o); end
    endtask

    task automatic test_random();
        logic [SW-1:0] pool [6];
        for (int i = 0; i < 6; i++) pool[i] = SW'(14'h0200 + i);
        for (int c = 0; c < 2000; c++) begin
            lookup_valid_i = $urandom_range(0, 1);
            lookup_sig_i = pool[$urandom_range(0, 5)];
            hit_valid_i = ($urandom_range(0, 2) != 0);
            hit_sig_i = pool[$urandom_range(0, 5)];
            for (int w = 0; w < NW; w++) begin
                evict_valid_i[w] = $urandom_range(0, 1);
                evict_reused_i[w] = ($urandom_range(0, 3) == 0);
                evict_sig_i[w] = pool[$urandom_range(0, 5)];
            end
            tick();
            checks += 4;
            if (ready_o !== 1'b1) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=1", c, ready_o); end
            if (pred_valid_o !== e_pv) begin failures++; $display("FAIL rnd_pv c=%0d got=%b exp=%b", c, pred_valid_o, e_pv); end
            if (pred_ctr_o !== CW'(e_ctr)) begin failures++; $display("FAIL rnd_ctr c=%0d got=%0d exp=%0d", c, pred_ctr_o, e_ctr); end
            if (pred_distant_o !== (e_ctr <= 0)) begin failures++; $display("FAIL rnd_distant c=%0d got=%b exp=%b", c, pred_distant_o, e_ctr <= 0); end
        end
        clear();
    endtask

    task automatic test_flush_run();
        repeat (4) begin evict_valid_i[3] = 1; evict_sig_i[3] = 14'h0123; tick(); end
        clear(); lookup_valid_i = 1; lookup_sig_i = 14'h0123; tick();
        checks++;
        if (pred_ctr_o !== 2'd0) begin failures++; $display("FAIL pre_flush_ctr got=%0d exp=0", pred_ctr_o); end
        clear(); flush_i = 1; hit_valid_i = 1; hit_sig_i = 14'h0123; tick(); clear();
        checks++;
        if (ready_o !== 1'b0) begin failures++; $display("FAIL flush_ready_drop got=%b exp=0", ready_o); end
        sweep_wait("flush_run", DEPTH);
        lookup_valid_i = 1; lookup_sig_i = 14'h0123; tick(); clear();
        checks += 2;
        if (pred_valid_o !== 1'b1) begin failures++; $display("FAIL post_flush_pv got=%b exp=1", pred_valid_o); end
        if (pred_ctr_o !== 2'd3) begin failures++; $display("FAIL post_flush_ctr got=%0d exp=3", pred_ctr_o); end
    endtask

    task automatic test_flush_mid_sweep();
        hit_valid_i = 1; hit_sig_i = 14'h0123; flush_i = 1; tick(); clear();
        for (int i = 0; i < DEPTH / 2; i++) begin
            lookup_valid_i = 1; lookup_sig_i = SW'($urandom); tick();
        end
        clear();
        checks += 2;
        if (ready_o !== 1'b0) begin failures++; $display("FAIL half_sweep_ready got=%b exp=0", ready_o); end
        if (pred_valid_o !== 1'b0) begin failures++; $display("FAIL half_sweep_pv got=%b exp=0", pred_valid_o); end
        flush_i = 1; tick(); clear();
        sweep_wait("flush_mid", DEPTH);
        lookup_valid_i = 1; lookup_sig_i = 14'h0055; tick(); clear();
        checks++;
        if (pred_ctr_o !== 2'd3) begin failures++; $display("FAIL post_mid_ctr got=%0d exp=3", pred_ctr_o); end
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_init_lookup();
        test_hit_saturate();
        test_evict_floor();
        test_merge();
        test_read_before_write();
        test_random();
        test_flush_run();
        test_flush_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
